// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and sequencer in front of a combinational 6-bit ALU.
// Optional carry counter output enabled by defining ALU_SEQ_COUT_CNT_EN.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_chain,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_out,
    input  logic         alu_cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_cout,
`ifdef ALU_SEQ_COUT_CNT_EN
    output logic [7:0]   cout_cnt,
`endif
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + 2 + 2 * W;
    localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_C = {(AW + 1){1'b0}};
    localparam logic [AW:0] ONE_C  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [EW-1:0]  fifo_mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic [AW:0]    count_nxt_s;
    state_t         state_r;
    logic [W-1:0]   last_result_r;

    logic           push_s;
    logic           pop_s;
    logic [EW-1:0]  head_s;
    logic           head_chain_s;
    logic [1:0]     head_op_s;
    logic [W-1:0]   head_a_s;
    logic [W-1:0]   head_b_s;

    assign push_s       = cmd_valid && cmd_ready;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign head_chain_s = head_s[EW-1];
    assign head_op_s    = head_s[2*W+1:2*W];
    assign head_a_s     = head_s[2*W-1:W];
    assign head_b_s     = head_s[W-1:0];

    // Pop decision: IDLE takes any queued command, HOLD only once the response is consumed.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = (count_r != ZERO_C);
            HOLD:    pop_s = (count_r != ZERO_C) && rsp_valid && rsp_ready;
            default: pop_s = 1'b0;
        endcase
    end

    // Next occupancy; push and pop together leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Command FIFO storage, pointers and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {EW{1'b0}};
            end
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= ZERO_C;
            cmd_ready <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {cmd_chain, cmd_op, cmd_a, cmd_b};
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r   <= count_nxt_s;
            cmd_ready <= (count_nxt_s != FULL_C);
        end
    end

    // Sequencer FSM: load ALU operands, capture result, hold it for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            alu_a         <= {W{1'b0}};
            alu_b         <= {W{1'b0}};
            alu_op        <= 2'b00;
            rsp_data      <= {W{1'b0}};
            rsp_cout      <= 1'b0;
            rsp_valid     <= 1'b0;
            last_result_r <= {W{1'b0}};
            busy          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        alu_a   <= head_chain_s ? last_result_r : head_a_s;
                        alu_b   <= head_b_s;
                        alu_op  <= head_op_s;
                        state_r <= EXEC;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= (count_nxt_s != ZERO_C);
                    end
                end
                EXEC: begin
                    rsp_data      <= alu_out;
                    rsp_cout      <= alu_cout;
                    last_result_r <= alu_out;
                    rsp_valid     <= 1'b1;
                    state_r       <= HOLD;
                    busy          <= 1'b1;
                end
                HOLD: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop_s) begin
                            alu_a   <= head_chain_s ? last_result_r : head_a_s;
                            alu_b   <= head_b_s;
                            alu_op  <= head_op_s;
                            state_r <= EXEC;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy    <= (count_nxt_s != ZERO_C);
                        end
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= (count_nxt_s != ZERO_C);
                end
            endcase
        end
    end

`ifdef ALU_SEQ_COUT_CNT_EN
    // Saturating count of captures that produced a carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_cnt <= 8'd0;
        end else if ((state_r == EXEC) && alu_cout && (cout_cnt != 8'hFF)) begin
            cout_cnt <= cout_cnt + 8'd1;
        end else begin
            cout_cnt <= cout_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with an ALU model and random traffic.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_a;
    logic [5:0] cmd_b;
    logic       cmd_chain;
    logic [5:0] alu_a;
    logic [5:0] alu_b;
    logic [1:0] alu_op;
    logic [5:0] alu_out;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_cout;
    logic       busy;
`ifdef ALU_SEQ_COUT_CNT_EN
    logic [7:0] cout_cnt;
`endif

    alu_cmd_sequencer #(.DEPTH(4), .W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout),
`ifdef ALU_SEQ_COUT_CNT_EN
        .cout_cnt(cout_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
        logic [1:0] op;
        logic [5:0] data;
        logic       cout;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   model_last = 0;

    // ALU behaviour: result modulo 64, carry when the true result exceeds 63.
    function automatic logic [6:0] alu_f(input logic [1:0] op, input int a, input int b);
        int r;
        logic c;
        case (op)
            2'd0:    r = (a + b) * 2;
            2'd1:    r = a + 3 * b;
            2'd2:    r = (64 - b) % 64;
            default: begin
                r = 2 * a - b;
                if (r < 0) r = -r;
            end
        endcase
        c = (op == 2'd2) ? (b == 0) : (r > 63);
        return {c, 6'(r % 64)};
    endfunction

    always_comb {alu_cout, alu_out} = alu_f(alu_op, int'(alu_a), int'(alu_b));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Acceptance monitor: every accepted command feeds the reference model.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            exp_t e;
            int ea;
            ea     = cmd_chain ? model_last : int'(cmd_a);
            e.a    = 6'(ea);
            e.b    = cmd_b;
            e.op   = cmd_op;
            {e.cout, e.data} = alu_f(cmd_op, ea, int'(cmd_b));
            model_last = int'(e.data);
            exp_q.push_back(e);
            acc_cnt++;
        end
    end

    // Response monitor: compare each consumed response with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            hs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got data=%0d with no command outstanding", rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_data !== e.data || rsp_cout !== e.cout || alu_a !== e.a ||
                    alu_b !== e.b || alu_op !== e.op) begin
                    errors++;
                    $display("FAIL rsp: got data=%0d cout=%0d a=%0d b=%0d op=%0d expected data=%0d cout=%0d a=%0d b=%0d op=%0d",
                             rsp_data, rsp_cout, alu_a, alu_b, alu_op, e.data, e.cout, e.a, e.b, e.op);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b, input logic ch);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = ch;
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [5:0] a,
                           input logic [5:0] b, input logic ch, input int exp_a,
                           input int exp_d, input int exp_c);
        int n;
        offer(op, a, b, ch);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, int'(rsp_valid), 1);
        chk({name, "_alu_a"}, int'(alu_a), exp_a);
        chk({name, "_data"}, int'(rsp_data), exp_d);
        chk({name, "_cout"}, int'(rsp_cout), exp_c);
        tick();
    endtask

    task automatic drain(input string name);
        int n;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, int'(exp_q.size() == 0 && !busy), 1);
    endtask

    initial begin
        int base;
        int prev;
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 6'd0; cmd_b = 6'd0; cmd_chain = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_alu_a", int'(alu_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Latency of a single command into an idle block.
        rsp_ready = 1'b1;
        offer(2'd1, 6'd10, 6'd20, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("lat_n_rsp_valid", int'(rsp_valid), 0);
        tick();
        chk("lat_n1_alu_op", int'(alu_op), 1);
        chk("lat_n1_alu_a", int'(alu_a), 10);
        chk("lat_n1_rsp_valid", int'(rsp_valid), 0);
        tick();
        chk("lat_n2_rsp_valid", int'(rsp_valid), 1);
        chk("lat_n2_data", int'(rsp_data), 6);
        chk("lat_n2_cout", int'(rsp_cout), 1);
        repeat (3) tick();

        run_one("op00", 2'd0, 6'd3, 6'd4, 1'b0, 3, 14, 0);
        run_one("op10", 2'd2, 6'd0, 6'd1, 1'b0, 0, 63, 0);
        run_one("op11_abs", 2'd3, 6'd5, 6'd30, 1'b0, 5, 20, 0);
        run_one("op11_max", 2'd3, 6'd63, 6'd0, 1'b0, 63, 62, 1);
        run_one("chain_a", 2'd1, 6'd1, 6'd2, 1'b0, 1, 7, 0);
        run_one("chain_b", 2'd1, 6'd0, 6'd1, 1'b1, 7, 10, 0);

        // Backpressure: DEPTH+1 accepted, then ready drops.
        rsp_ready = 1'b0;
        base = acc_cnt;
        prev = acc_cnt;
        offer(2'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
        repeat (12) begin
            tick();
            if (acc_cnt != prev) begin
                prev = acc_cnt;
                offer(2'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
            end
        end
        chk("bp_accepted", acc_cnt - base, 5);
        chk("bp_cmd_ready", int'(cmd_ready), 0);
        chk("bp_busy", int'(busy), 1);
        hs_cyc.delete();
        rsp_ready = 1'b1;
        n = 0;
        while (acc_cnt - base < 6 && n < 20) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("bp_sixth_accepted", acc_cnt - base, 6);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("bp_results", hs_cyc.size(), 6);
        for (int i = 1; i < 6 && i < hs_cyc.size(); i++) begin
            chk("bp_interval", hs_cyc[i] - hs_cyc[i-1], 2);
        end
        drain("bp");

        // Reset in HOLD with three commands queued.
        rsp_ready = 1'b0;
        base = acc_cnt;
        offer(2'd1, 6'd5, 6'd5, 1'b0);
        n = 0;
        while (acc_cnt - base < 4 && n < 20) begin
            tick();
            offer(2'($urandom), 6'($urandom), 6'($urandom), 1'b0);
            n++;
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("mid_pre_valid", int'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_last = 0;
        chk("mid_rsp_valid", int'(rsp_valid), 0);
        chk("mid_alu", int'({alu_a, alu_b, alu_op}), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_cmd_ready", int'(cmd_ready), 1);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk("mid_idle_after", int'(rsp_valid || busy), 0);
        run_one("chain_empty", 2'd1, 6'd9, 6'd2, 1'b1, 0, 6, 0);

        // Random traffic against the scoreboard.
        repeat (600) begin
            if ($urandom_range(0, 9) < 6) begin
                offer(2'($urandom), 6'($urandom), 6'($urandom), ($urandom_range(0, 3) == 0));
            end else begin
                cmd_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain("random");

`ifdef ALU_SEQ_COUT_CNT_EN
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_last = 0;
        chk("cnt_reset", int'(cout_cnt), 0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        base = acc_cnt;
        n = 0;
        offer(2'd1, 6'd63, 6'd63, 1'b0);
        while (acc_cnt - base < 300 && n < 2000) begin
            tick();
            n++;
        end
        drain("cnt");
        chk("cnt_saturate", int'(cout_cnt), 255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
